// File: rtl/press_counter_fsm.sv
// Multi-channel push-button press counter.
// Each channel: 2-flop synchroniser -> debounce/hold FSM -> accepted-press
// counter and error counter (glitch or stuck button), plus a one-cycle
// pulse per accepted press. Channels share only clk, rst and clr.
module press_counter_fsm #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4,
  parameter int HOLD_MAX = 255,
  parameter bit SATURATE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [CHANNELS-1:0]       press,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS*WIDTH-1:0] err,
  output logic [CHANNELS-1:0]       pulse
);

  // The timer only ever needs to reach max(DEBOUNCE, HOLD_MAX) - 1.
  localparam int TMAX = (DEBOUNCE > HOLD_MAX) ? DEBOUNCE : HOLD_MAX;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    HELD  = 2'd2,
    STUCK = 2'd3
  } state_t;

  // Counter increment: hold at all-ones when saturating, else wrap to 0.
  function automatic logic [WIDTH-1:0] cnt_inc(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (SATURATE && (v == {WIDTH{1'b1}}))
      r = v;
    else
      r = v + 1'b1;
    return r;
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

    logic             sync_p0;
    logic             sync_p1;
    state_t           state;
    state_t           state_nx;
    logic [TW-1:0]    t;
    logic [TW-1:0]    t_nx;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nx;
    logic [WIDTH-1:0] ecnt;
    logic [WIDTH-1:0] ecnt_nx;
    logic             pls;
    logic             inc_cnt;
    logic             inc_err;

    // Two-flop synchroniser for the asynchronous button pin.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_p0 <= 1'b0;
        sync_p1 <= 1'b0;
      end else begin
        sync_p0 <= press[i];
        sync_p1 <= sync_p0;
      end
    end

    // Debounce/hold FSM: next state, timer and event strobes.
    always_comb begin
      state_nx = state;
      t_nx     = t;
      inc_cnt  = 1'b0;
      inc_err  = 1'b0;
      case (state)
        IDLE: begin
          if (sync_p1) begin
            state_nx = ARM;
            t_nx     = '0;
          end
        end
        ARM: begin
          if (!sync_p1) begin
            // Released before the debounce window closed: a glitch.
            state_nx = IDLE;
            inc_err  = 1'b1;
          end else if (t == DEB_LAST) begin
            state_nx = HELD;
            t_nx     = '0;
            inc_cnt  = 1'b1;
          end else begin
            t_nx = t + 1'b1;
          end
        end
        HELD: begin
          if (!sync_p1) begin
            state_nx = IDLE;
          end else if (t == HOLD_LAST) begin
            // Held too long: report once, then park in STUCK until release.
            state_nx = STUCK;
            inc_err  = 1'b1;
          end else begin
            t_nx = t + 1'b1;
          end
        end
        STUCK: begin
          if (!sync_p1) state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
          t_nx     = '0;
        end
      endcase
    end

    // Counter updates; clear takes priority over a same-edge increment.
    always_comb begin
      cnt_nx  = cnt;
      ecnt_nx = ecnt;
      if (clr) begin
        cnt_nx  = '0;
        ecnt_nx = '0;
      end else begin
        if (inc_cnt) cnt_nx  = cnt_inc(cnt);
        if (inc_err) ecnt_nx = cnt_inc(ecnt);
      end
    end

    // State, timer, counters and pulse registers.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= IDLE;
        t     <= '0;
        cnt   <= '0;
        ecnt  <= '0;
        pls   <= 1'b0;
      end else begin
        state <= state_nx;
        t     <= t_nx;
        cnt   <= cnt_nx;
        ecnt  <= ecnt_nx;
        pls   <= inc_cnt;
      end
    end

    assign count[i*WIDTH +: WIDTH] = cnt;
    assign err[i*WIDTH +: WIDTH]   = ecnt;
    assign pulse[i]                = pls;
  end

endmodule

// File: tb/tb_press_counter_fsm.sv
// Testbench for press_counter_fsm: three instances share one stimulus
// (defaults; WIDTH=4/HOLD_MAX=16 saturating; same but wrapping).
module tb_press_counter_fsm;

  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            clr;
  logic [CH-1:0]   press;

  logic [CH*8-1:0] cnt_a, err_a;
  logic [CH-1:0]   pls_a;
  logic [CH*4-1:0] cnt_s, err_s;
  logic [CH-1:0]   pls_s;
  logic [CH*4-1:0] cnt_w, err_w;
  logic [CH-1:0]   pls_w;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  press_counter_fsm #(.CHANNELS(CH)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .press(press),
    .count(cnt_a), .err(err_a), .pulse(pls_a)
  );

  press_counter_fsm #(.CHANNELS(CH), .WIDTH(4), .DEBOUNCE(4), .HOLD_MAX(16), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .press(press),
    .count(cnt_s), .err(err_s), .pulse(pls_s)
  );

  press_counter_fsm #(.CHANNELS(CH), .WIDTH(4), .DEBOUNCE(4), .HOLD_MAX(16), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .clr(clr), .press(press),
    .count(cnt_w), .err(err_w), .pulse(pls_w)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; everything is driven and sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    press = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic hold(input logic [CH-1:0] m, input int n);
    press = m;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int npls;
    int exp_s;
    rst   = 1'b0;
    clr   = 1'b0;
    press = 4'b1111;

    // Reset hold with all buttons pressed.
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rst_cnt_a", cnt_a, 0);
      chk("rst_err_a", err_a, 0);
      chk("rst_pls", {pls_a, pls_s, pls_w}, 0);
      chk("rst_cnt_sw", {cnt_s, cnt_w, err_s, err_w}, 0);
    end
    press = '0;
    rst   = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("post_rst_cnt", cnt_a, 0);
    chk("post_rst_err", err_a, 0);
    chk("post_rst_pls", pls_a, 0);

    // Clean press on ch0: count at edge e0+6, pulse for that one cycle.
    press = 4'b0001;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk($sformatf("clean_cnt_e%0d", j), cnt_a[0 +: 8], (j >= 6) ? 1 : 0);
      chk($sformatf("clean_pls_e%0d", j), pls_a, (j == 6) ? 1 : 0);
    end
    idle(6);
    chk("clean_err0", err_a[0 +: 8], 0);
    chk("clean_others", cnt_a[31:8], 0);
    chk("clean_cnt_s", cnt_s, 1);

    // Glitch on ch1: 3 cycles high.
    npls = 0;
    press = 4'b0010;
    for (int k = 0; k < 3; k++) begin tick(); npls += int'(pls_a[1]); end
    press = '0;
    for (int k = 0; k < 6; k++) begin tick(); npls += int'(pls_a[1]); end
    chk("glitch_err1", err_a[8 +: 8], 1);
    chk("glitch_cnt1", cnt_a[8 +: 8], 0);
    chk("glitch_pulse", npls, 0);
    hold(4'b0010, 10);
    idle(6);
    chk("glitch_then_cnt1", cnt_a[8 +: 8], 1);
    chk("glitch_then_err1", err_a[8 +: 8], 1);

    // Stuck on ch2 (HOLD_MAX=16 instances): err 16 edges after count.
    press = 4'b0100;
    for (int j = 0; j < 40; j++) begin
      tick();
      chk($sformatf("stuck_cnt_e%0d", j), cnt_s[8 +: 4], (j >= 6) ? 1 : 0);
      chk($sformatf("stuck_err_e%0d", j), err_s[8 +: 4], (j >= 22) ? 1 : 0);
    end
    idle(6);
    chk("stuck_err_a", err_a[16 +: 8], 0);
    chk("stuck_cnt_a", cnt_a[16 +: 8], 1);
    hold(4'b0100, 10);
    idle(6);
    chk("stuck_then_cnt_s", cnt_s[8 +: 4], 2);
    chk("stuck_then_err_s", err_s[8 +: 4], 1);
    chk("stuck_then_err_w", err_w[8 +: 4], 1);

    // Width limits: 17 presses on ch3.
    npls = 0;
    for (int n = 1; n <= 17; n++) begin
      press = 4'b1000;
      for (int k = 0; k < 7; k++) begin tick(); npls += int'(pls_a[3]); end
      press = '0;
      for (int k = 0; k < 4; k++) begin tick(); npls += int'(pls_a[3]); end
      exp_s = (n > 15) ? 15 : n;
      chk($sformatf("sat_cnt_n%0d", n), cnt_s[12 +: 4], exp_s);
      chk($sformatf("wrap_cnt_n%0d", n), cnt_w[12 +: 4], n % 16);
    end
    chk("width_cnt_a", cnt_a[24 +: 8], 17);
    chk("width_pulses", npls, 17);
    chk("width_err_a", err_a[24 +: 8], 0);

    // clr on the same edge as an accepted press: clr wins, pulse still fires.
    press = 4'b0001;
    for (int j = 0; j < 10; j++) begin
      clr = (j == 6);
      tick();
      if (j == 6) begin
        chk("clr_pls", pls_a, 4'b0001);
        chk("clr_cnt_a", cnt_a, 0);
        chk("clr_err_a", err_a, 0);
        chk("clr_cnt_s", {cnt_s, err_s}, 0);
      end
    end
    clr = 1'b0;
    idle(6);
    chk("clr_after_cnt", cnt_a, 0);

    // Reset mid-ARM on ch1: no count or err change afterwards.
    press = 4'b0010;
    for (int j = 0; j < 4; j++) tick();
    rst = 1'b0;
    #1;
    chk("midrst_cnt", cnt_a, 0);
    chk("midrst_err", err_a, 0);
    chk("midrst_pls", pls_a, 0);
    press = '0;
    tick();
    tick();
    rst = 1'b1;
    idle(6);
    chk("midrst_after_err", err_a, 0);
    chk("midrst_after_cnt", cnt_a, 0);
    press = 4'b0010;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j == 5) chk("midrst_fresh_e5", cnt_a[8 +: 8], 0);
      if (j == 6) chk("midrst_fresh_e6", cnt_a[8 +: 8], 1);
    end
    idle(6);

    // Simultaneous presses on ch0 and ch3.
    press = 4'b1001;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j == 6) begin
        chk("sim_pls", pls_a, 4'b1001);
        chk("sim_cnt_a", cnt_a, 32'h0100_0101);
      end
    end
    idle(6);
    chk("sim_cnt_w", cnt_w, 16'h1011);
    chk("sim_err_a", err_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
